seg7_scan_ctrl: RTL and testbench

Scan and update controller for the 4-digit seven-segment display driver. It generates the 2-bit digit-select sequence at a programmable dwell rate and holds the 32-bit per-digit segment pattern word. It accepts display writes from one requester over a req/ack handshake, in hex or raw mode. Writes are committed only at frame boundaries, so a digit never shows a mix of old and new data. Sits between the CPU-side I/O register and the segment driver: `scan` and `seg_data` feed the driver's `scan` and `data` inputs.

---
 rtl/seg7_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Purpose  : Digit-scan sequencer and frame-synchronous display-word update
//             for a 4-digit seven-segment driver. Optional feature macro:
//             SEG7_BLINK_EN (per-digit blink mask, 32-frame blink phase).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl #(
    parameter int unsigned DWELL = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req,
    input  logic        wr_mode,
    input  logic [31:0] wr_data,
    output logic        wr_ack,
    output logic        busy,
    output logic [1:0]  scan,
    output logic [31:0] seg_data,
    output logic        frame
);

    localparam logic [23:0] CNT_MAX = 24'(DWELL - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] cnt_q;
    logic [1:0]  scan_q;
    logic        frame_q;
    logic        ack_q;
    logic        pend_mode_q;
    logic [31:0] pend_data_q;
    logic [31:0] active_q;

    logic        w_last;
    logic        w_boundary;
    logic        w_capture;
    logic        w_commit;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] p;
        case (nib)
            4'h0: p = 7'h40;  4'h1: p = 7'h79;  4'h2: p = 7'h24;  4'h3: p = 7'h30;
            4'h4: p = 7'h19;  4'h5: p = 7'h12;  4'h6: p = 7'h02;  4'h7: p = 7'h78;
            4'h8: p = 7'h00;  4'h9: p = 7'h10;  4'hA: p = 7'h08;  4'hB: p = 7'h03;
            4'hC: p = 7'h46;  4'hD: p = 7'h21;  4'hE: p = 7'h06;
            default: p = 7'h0E;
        endcase
        return p;
    endfunction

    // Digit n takes nibble [15-4n:12-4n]; dp segment is active-low, lit by bit 19-n.
    function automatic logic [31:0] hex_word(input logic [31:0] d);
        logic [31:0] w;
        w = 32'hFFFF_FFFF;
        for (int n = 0; n < 4; n++) begin
            w[31-8*n -: 8] = {~d[19-n], hex7(d[15-4*n -: 4])};
        end
        return w;
    endfunction

    assign w_last     = (cnt_q == CNT_MAX);
    assign w_boundary = w_last && (scan_q == 2'd3);
    assign w_capture  = (state_q == ST_IDLE) && wr_req && !ack_q;
    assign w_commit   = (state_q == ST_PEND) && w_boundary;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (wr_req && !ack_q) state_d = ST_PEND;
            ST_PEND: if (w_boundary)       state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            scan_q      <= '0;
            frame_q     <= 1'b0;
            ack_q       <= 1'b0;
            pend_mode_q <= 1'b0;
            pend_data_q <= '0;
            active_q    <= 32'hFFFF_FFFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= w_last ? 24'd0 : cnt_q + 24'd1;
            if (w_last) scan_q <= scan_q + 2'd1;
            frame_q <= w_boundary;
            ack_q   <= w_commit;
            if (w_capture) begin
                pend_mode_q <= wr_mode;
                pend_data_q <= wr_data;
            end
            if (w_commit) begin
                active_q <= pend_mode_q ? pend_data_q : hex_word(pend_data_q);
            end
        end
    end

`ifdef SEG7_BLINK_EN
    logic [3:0]  mask_q;
    logic [4:0]  fcnt_q;
    logic        phase_q;
    logic [31:0] w_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q  <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            if (w_commit) mask_q <= pend_mode_q ? 4'h0 : pend_data_q[23:20];
            if (w_boundary) begin
                fcnt_q <= fcnt_q + 5'd1;
                if (fcnt_q == 5'd31) phase_q <= ~phase_q;
            end
        end
    end

    // Blanked digits go fully dark, decimal point included.
    always_comb begin
        w_seg = active_q;
        for (int n = 0; n < 4; n++) begin
            if (phase_q && mask_q[n]) w_seg[31-8*n -: 8] = 8'hFF;
        end
    end

    assign seg_data = w_seg;
`else
    assign seg_data = active_q;
`endif

    assign wr_ack = ack_q;
    assign busy   = (state_q == ST_PEND);
    assign scan   = scan_q;
    assign frame  = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
//  Module   : tb_seg7_scan_ctrl
//  Purpose  : Directed self-checking bench for seg7_scan_ctrl at DWELL=4.
//             Blink checks are included when SEG7_BLINK_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_req = 1'b0;
    logic        wr_mode = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ack;
    logic        busy;
    logic [1:0]  scan;
    logic [31:0] seg_data;
    logic        frame;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;

    seg7_scan_ctrl #(.DWELL(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .wr_req   (wr_req),
        .wr_mode  (wr_mode),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .busy     (busy),
        .scan     (scan),
        .seg_data (seg_data),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    // Raise a request at the current negedge, then wait (bounded) for its ack.
    task automatic write_wait(input string tag, input logic mode, input logic [31:0] data,
                              input int exp_cyc, input logic [31:0] exp_seg);
        bit seen;
        wr_mode = mode;
        wr_data = data;
        wr_req  = 1'b1;
        step();
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (wr_ack) seen = 1'b1;
            else step();
        end
        chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
        chk({tag, "_ack_cyc"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_seg"}, seg_data, exp_seg);
        chk({tag, "_scan0"}, 32'(scan), 32'd0);
        chk({tag, "_frame"}, 32'(frame), 32'd1);
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        do_reset();

        // Free-running scan after reset: each digit held 4 cycles, frame every 16.
        for (int k = 0; k < 40; k++) begin
            chk("scan_seq", 32'(scan), 32'((k / 4) % 4));
            chk("frame_seq", 32'(frame), 32'((k > 0 && k % 16 == 0) ? 1 : 0));
            if (k % 8 == 0) begin
                chk("reset_seg", seg_data, 32'hFFFF_FFFF);
                chk("reset_busy", 32'(busy), 32'd0);
                chk("reset_ack", 32'(wr_ack), 32'd0);
            end
            step();
        end

        // Hex 1234 captured at cyc 40 -> ack at the next frame start, cyc 48.
        write_wait("hex1234", 1'b0, 32'h0000_1234, 48, 32'hF9A4_B099);
        wr_req = 1'b0;
        step();
        chk("hex1234_ack_once", 32'(wr_ack), 32'd0);
        chk("hex1234_idle", 32'(busy), 32'd0);

        // dp lit on digit 0 only.
        write_wait("hexABCD", 1'b0, 32'h0008_ABCD, 64, 32'h0883_C6A1);
        wr_req = 1'b0;
        step();

        // Raw write with wr_req held through ack: second capture, ack 16 later.
        write_wait("raw1", 1'b1, 32'h1234_5678, 80, 32'h1234_5678);
        step();
        chk("raw_gap_ack", 32'(wr_ack), 32'd0);
        chk("raw_gap_busy", 32'(busy), 32'd0);
        write_wait("raw2", 1'b1, 32'h1234_5678, 96, 32'h1234_5678);
        wr_req = 1'b0;
        step();

        // Fresh reset, capture, then reset 3 cycles later: write discarded.
        do_reset();
        wr_mode = 1'b0;
        wr_data = 32'h0000_1234;
        wr_req  = 1'b1;
        step();
        wr_req = 1'b0;
        chk("rstpend_busy", 32'(busy), 32'd1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
        chk("rstpend_busy0", 32'(busy), 32'd0);
        chk("rstpend_scan0", 32'(scan), 32'd0);
        for (int k = 0; k < 40; k++) begin
            chk("rstpend_no_ack", 32'(wr_ack), 32'd0);
            chk("rstpend_seg", seg_data, 32'hFFFF_FFFF);
            step();
        end

`ifdef SEG7_BLINK_EN
        do_reset();
        write_wait("blink", 1'b0, 32'h0010_0000, 16, 32'hC0C0_C0C0);
        wr_req = 1'b0;
        while (cyc < 500) step();
        chk("blink_ph0", seg_data, 32'hC0C0_C0C0);
        while (cyc < 520) step();
        chk("blink_ph1", seg_data, 32'hFFC0_C0C0);
        while (cyc < 1030) step();
        chk("blink_ph0b", seg_data, 32'hC0C0_C0C0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

`default_nettype wire
